// File: rtl/zbt_pkg.sv
// Shared ZBT write-path definitions: FSM states, write latency and point packing.
package zbt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } zbt_state_e;

  localparam int unsigned ZBT_WR_LAT = 2;
  localparam int unsigned ZBT_PACK_W = 64;

  // Packs {zeros, x, y} with y in the low y_w bits; fields are masked to their widths.
  function automatic logic [ZBT_PACK_W-1:0] zbt_pack_point(
    input int unsigned           x_w,
    input int unsigned           y_w,
    input int unsigned           data_w,
    input logic [ZBT_PACK_W-1:0] x,
    input logic [ZBT_PACK_W-1:0] y
  );
    logic [ZBT_PACK_W-1:0] xm;
    logic [ZBT_PACK_W-1:0] ym;
    logic [ZBT_PACK_W-1:0] dm;
    xm = (ZBT_PACK_W'(1) << x_w) - ZBT_PACK_W'(1);
    ym = (ZBT_PACK_W'(1) << y_w) - ZBT_PACK_W'(1);
    dm = (ZBT_PACK_W'(1) << data_w) - ZBT_PACK_W'(1);
    return (((x & xm) << y_w) | (y & ym)) & dm;
  endfunction

endpackage

// File: rtl/zbt_wdata_pipe.sv
// LAT-deep register pipeline carrying ZBT write data and its bus drive enable.
module zbt_wdata_pipe
  import zbt_pkg::*;
#(
  parameter int unsigned DATA_W = 36,
  parameter int unsigned LAT    = ZBT_WR_LAT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_oe,
  output logic [DATA_W-1:0] out_data,
  output logic              out_oe
);

  logic [DATA_W-1:0] data_q [LAT];
  logic [LAT-1:0]    oe_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < LAT; i++) data_q[i] <= '0;
      oe_q <= '0;
    end else begin
      data_q[0] <= in_data;
      oe_q[0]   <= in_oe;
      for (int unsigned i = 1; i < LAT; i++) begin
        data_q[i] <= data_q[i-1];
        oe_q[i]   <= oe_q[i-1];
      end
    end
  end

  assign out_data = data_q[LAT-1];
  assign out_oe   = oe_q[LAT-1];

endmodule

// File: rtl/zbt_point_writer.sv
// Streams packed (x, y) points into a ZBT address window with pipelined writes.
// Define ZBT_POINT_CLEAR_EN to zero-fill the DEPTH window at the start of each frame.
module zbt_point_writer
  import zbt_pkg::*;
#(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 36,
  parameter int unsigned X_W    = 10,
  parameter int unsigned Y_W    = 11,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              start,
  input  logic              end_frame,
  input  logic              pt_valid,
  input  logic [X_W-1:0]    pt_x,
  input  logic [Y_W-1:0]    pt_y,
  output logic              pt_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we_n,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_data_oe,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  zbt_state_e        state;
  logic [ADDR_W-1:0] base_q;
  logic [1:0]        drain_cnt;
  logic [DATA_W-1:0] wr_data;
  logic              wr_oe;
  logic [DATA_W-1:0] packed_word;
  logic [ADDR_W:0]   count_inc;
  logic              accept;
`ifdef ZBT_POINT_CLEAR_EN
  logic [ADDR_W:0]   clr_cnt;
`endif

  always_comb begin
    accept      = pt_valid && pt_ready;
    count_inc   = count + (ADDR_W+1)'(1);
    packed_word = DATA_W'(zbt_pack_point(X_W, Y_W, DATA_W,
                                         ZBT_PACK_W'(pt_x), ZBT_PACK_W'(pt_y)));
  end

  // Address/we_n and the first data stage are registered together; the pipe adds ZBT_WR_LAT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      base_q    <= '0;
      drain_cnt <= '0;
      count     <= '0;
      ram_addr  <= '0;
      ram_we_n  <= 1'b1;
      wr_data   <= '0;
      wr_oe     <= 1'b0;
      pt_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef ZBT_POINT_CLEAR_EN
      clr_cnt   <= '0;
`endif
    end else begin
      ram_we_n <= 1'b1;
      wr_oe    <= 1'b0;
      wr_data  <= '0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            base_q <= base_addr;
            count  <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
`ifdef ZBT_POINT_CLEAR_EN
            clr_cnt  <= '0;
            pt_ready <= 1'b0;
            state    <= ST_CLEAR;
`else
            pt_ready <= 1'b1;
            state    <= ST_RUN;
`endif
          end
        end
`ifdef ZBT_POINT_CLEAR_EN
        ST_CLEAR: begin
          ram_addr <= base_q + clr_cnt[ADDR_W-1:0];
          ram_we_n <= 1'b0;
          wr_oe    <= 1'b1;
          clr_cnt  <= clr_cnt + (ADDR_W+1)'(1);
          if (clr_cnt == DEPTH_C - (ADDR_W+1)'(1)) begin
            pt_ready <= 1'b1;
            state    <= ST_RUN;
          end
        end
`endif
        ST_RUN: begin
          if (accept) begin
            ram_addr <= base_q + count[ADDR_W-1:0];
            ram_we_n <= 1'b0;
            wr_oe    <= 1'b1;
            wr_data  <= packed_word;
            count    <= count_inc;
          end
          if ((accept && count_inc == DEPTH_C) || end_frame) begin
            pt_ready  <= 1'b0;
            drain_cnt <= '0;
            state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt + 2'd1;
          if (drain_cnt == 2'(ZBT_WR_LAT - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: begin
          pt_ready <= 1'b0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  zbt_wdata_pipe #(
    .DATA_W (DATA_W),
    .LAT    (ZBT_WR_LAT)
  ) u_wdata_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (wr_data),
    .in_oe    (wr_oe),
    .out_data (ram_data),
    .out_oe   (ram_data_oe)
  );

endmodule

// File: tb/tb_zbt_point_writer.sv
// Scoreboard bench for zbt_point_writer: randomized frames against an arithmetic reference model.
module tb_zbt_point_writer;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 36;
  localparam int unsigned X_W    = 10;
  localparam int unsigned Y_W    = 11;
`ifdef ZBT_POINT_CLEAR_EN
  localparam int unsigned DEPTH  = 8;
`else
  localparam int unsigned DEPTH  = 4;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              start = 1'b0;
  logic              end_frame = 1'b0;
  logic              pt_valid = 1'b0;
  logic [X_W-1:0]    pt_x = '0;
  logic [Y_W-1:0]    pt_y = '0;
  logic              pt_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we_n;
  logic [DATA_W-1:0] ram_data;
  logic              ram_data_oe;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;

  zbt_point_writer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .X_W    (X_W),
    .Y_W    (Y_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .base_addr   (base_addr),
    .start       (start),
    .end_frame   (end_frame),
    .pt_valid    (pt_valid),
    .pt_x        (pt_x),
    .pt_y        (pt_y),
    .pt_ready    (pt_ready),
    .ram_addr    (ram_addr),
    .ram_we_n    (ram_we_n),
    .ram_data    (ram_data),
    .ram_data_oe (ram_data_oe),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct { logic [ADDR_W-1:0] a; int unsigned c; } aexp_t;
  typedef struct { logic [DATA_W-1:0] d; int unsigned c; } dexp_t;
  aexp_t aq[$];
  dexp_t dq[$];
  aexp_t ea;
  dexp_t ed;

  logic [X_W-1:0] px[$];
  logic [Y_W-1:0] py[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_word(input int unsigned x, input int unsigned y);
    logic [63:0] w;
    w = 64'(x) * (64'd1 << Y_W) + 64'(y);
    return w[DATA_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] model_addr(input logic [ADDR_W-1:0] base, input int unsigned off);
    logic [63:0] s;
    s = (64'(base) + 64'(off)) % (64'd1 << ADDR_W);
    return s[ADDR_W-1:0];
  endfunction

  // Called at the negedge before the write edge; delta shifts for queued clear writes.
  task automatic expect_write(input logic [ADDR_W-1:0] base, input int unsigned off,
                              input logic [DATA_W-1:0] data, input int unsigned delta);
    aexp_t a;
    dexp_t d;
    a.a = model_addr(base, off);
    a.c = cyc + 1 + delta;
    d.d = data;
    d.c = cyc + 3 + delta;
    aq.push_back(a);
    dq.push_back(d);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (ram_we_n == 1'b0) begin
        if (aq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr 0x%0h expected no write (cycle %0d)", ram_addr, cyc);
        end else begin
          ea = aq.pop_front();
          check("wr_addr", 64'(ram_addr), 64'(ea.a));
          check("wr_addr_cycle", 64'(cyc), 64'(ea.c));
        end
      end
      if (ram_data_oe == 1'b1) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_data: got data 0x%0h expected no drive (cycle %0d)", ram_data, cyc);
        end else begin
          ed = dq.pop_front();
          check("wr_data", 64'(ram_data), 64'(ed.d));
          check("wr_data_cycle", 64'(cyc), 64'(ed.c));
        end
      end
    end
  end

  task automatic do_start(input logic [ADDR_W-1:0] base);
    base_addr = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base_addr = ADDR_W'($urandom);
`ifdef ZBT_POINT_CLEAR_EN
    for (int unsigned i = 0; i < DEPTH; i++) expect_write(base, i, '0, i);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      check("clear_ready_low", 64'(pt_ready), 64'd0);
      @(negedge clk);
    end
`endif
  endtask

  task automatic run_frame(input logic [ADDR_W-1:0] base, input int unsigned end_idx);
    int unsigned npts;
    int unsigned n = 0;
    int unsigned it = 0;
    int unsigned e = 0;
    int unsigned exp_n;
    bit ended = 0;
    bit have;
    npts = px.size();
    if (end_idx < npts) exp_n = (end_idx + 1 < DEPTH) ? end_idx + 1 : DEPTH;
    else                exp_n = (npts < DEPTH) ? npts : DEPTH;
    do_start(base);
    while (!ended && it < 64) begin
      have = (n < npts);
      pt_valid = have;
      if (have) begin
        pt_x = px[n];
        pt_y = py[n];
      end
      end_frame = have ? (n == end_idx) : 1'b1;
      start = (it == 1);
      base_addr = ADDR_W'($urandom);
      check("run_ready", 64'(pt_ready), 64'd1);
      if (have && pt_ready) begin
        expect_write(base, n, model_word(px[n], py[n]), 0);
        n++;
        if (end_frame || n == DEPTH) ended = 1;
      end else if (!have) begin
        ended = 1;
      end
      if (ended) e = cyc + 1;
      it++;
      @(negedge clk);
    end
    if (!ended) begin
      checks++; errors++;
      $display("FAIL frame_timeout: got %0d accepts expected frame end", n);
    end
    start = 1'b0;
    end_frame = 1'b0;
    pt_valid = 1'b1;
    pt_x = X_W'($urandom);
    pt_y = Y_W'($urandom);
    for (int unsigned i = 0; i < 2; i++) begin
      check("drain_ready_low", 64'(pt_ready), 64'd0);
      check("drain_busy", 64'(busy), 64'd1);
      check("drain_not_done", 64'(done), 64'd0);
      @(negedge clk);
    end
    pt_valid = 1'b0;
    for (int unsigned i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
    #1;
    check("done", 64'(done), 64'd1);
    check("done_cycle", 64'(cyc), 64'(e + 2));
    check("busy_at_done", 64'(busy), 64'd0);
    check("accepts", 64'(n), 64'(exp_n));
    check("count", 64'(count), 64'(exp_n));
    check("addr_queue_empty", 64'(aq.size()), 64'd0);
    check("data_queue_empty", 64'(dq.size()), 64'd0);
  endtask

  task automatic rand_points(input int unsigned k);
    px.delete();
    py.delete();
    for (int unsigned i = 0; i < k; i++) begin
      px.push_back(X_W'($urandom));
      py.push_back(Y_W'($urandom));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_we_n", 64'(ram_we_n), 64'd1);
    check("rst_ram_data", 64'(ram_data), 64'd0);
    check("rst_data_oe", 64'(ram_data_oe), 64'd0);
    check("rst_pt_ready", 64'(pt_ready), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    pt_valid = 1'b1;
    end_frame = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready_low", 64'(pt_ready), 64'd0);
    check("idle_not_busy", 64'(busy), 64'd0);
    pt_valid = 1'b0;
    end_frame = 1'b0;

    px = '{10'd500, 10'd1, 10'd1023};
    py = '{11'd500, 11'd2, 11'd2047};
    run_frame(19'h00100, 2);

    rand_points(DEPTH + 2);
    run_frame(ADDR_W'($urandom), 99);

    rand_points(2);
    run_frame({ADDR_W{1'b1}}, 1);

    rand_points(0);
    run_frame(19'h00040, 0);

    rand_points(3);
    run_frame(19'h00040, 99);

    // Reset one cycle after an accept: the pending data must never reach the bus.
    @(negedge clk);
    do_start(19'h00200);
    pt_valid = 1'b1;
    pt_x = X_W'($urandom);
    pt_y = Y_W'($urandom);
    check("rm_ready", 64'(pt_ready), 64'd1);
    expect_write(19'h00200, 0, model_word(pt_x, pt_y), 0);
    @(negedge clk);
    pt_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("rm_we_n", 64'(ram_we_n), 64'd1);
    check("rm_data_oe", 64'(ram_data_oe), 64'd0);
    check("rm_count", 64'(count), 64'd0);
    check("rm_ready_low", 64'(pt_ready), 64'd0);
    check("rm_busy", 64'(busy), 64'd0);
    check("rm_addr_seen", 64'(aq.size()), 64'd0);
    dq.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("rm_idle_busy", 64'(busy), 64'd0);
    check("rm_idle_done", 64'(done), 64'd0);

    for (int k = 0; k < 6; k++) begin
      int unsigned np;
      logic [ADDR_W-1:0] b;
      np = $urandom_range(0, DEPTH + 1);
      rand_points(np);
      b = (k % 2 == 0) ? ADDR_W'({ADDR_W{1'b1}} - ADDR_W'($urandom_range(0, 3))) : ADDR_W'($urandom);
      run_frame(b, $urandom_range(0, np + 1));
    end

    repeat (5) @(negedge clk);
    #1;
    check("final_addr_queue", 64'(aq.size()), 64'd0);
    check("final_data_queue", 64'(dq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
